vga_rect_fill: RTL and testbench

- Drawing engine that sits directly upstream of the SDRAM frame-buffer VGA core.
- Accepts one rectangle-fill command at a time, with two corners and a colour.
- Walks the rectangle in raster order (x fastest, then y) and drives the core's pixel source write port.
- Lets software or a host FSM paint solid regions without issuing per-pixel writes.

---
 rtl/vga_rect_pkg.sv | 34 +++
 rtl/vga_rect_fill.sv | 212 +++++++++++++++++++++
 tb/tb_vga_rect_fill.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_rect_pkg.sv
// ----------------------------------------------------------------------------
// vga_rect_pkg
//
// Shared types for the rectangle-fill drawing engine.
//   - rect_state_t : engine states (IDLE, SETUP, FILL, DONE)
//   - rect_cmd_t   : one fill command as presented on the command port
//                    (two corners in either order plus a fill colour)
//
// The field widths of rect_cmd_t come from the RECT_* localparams below; the
// engine uses the same values as defaults for its width parameters, so a
// build that changes those widths must change them here as well.
// ----------------------------------------------------------------------------
package vga_rect_pkg;

    localparam int RECT_H_SIZE   = 10;
    localparam int RECT_V_SIZE   = 10;
    localparam int RECT_RGB_SIZE = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } rect_state_t;

    typedef struct packed {
        logic [RECT_H_SIZE-1:0]   x0;
        logic [RECT_H_SIZE-1:0]   x1;
        logic [RECT_V_SIZE-1:0]   y0;
        logic [RECT_V_SIZE-1:0]   y1;
        logic [RECT_RGB_SIZE-1:0] color;
    } rect_cmd_t;

endpackage

// File: rtl/vga_rect_fill.sv
// ----------------------------------------------------------------------------
// vga_rect_fill
//
// Rectangle-fill drawing engine placed directly upstream of the SDRAM
// frame-buffer VGA core. It takes one command (two corners + colour), walks
// the rectangle in raster order (x fastest, then y) and drives the core's
// pixel-source write port, one pixel per accepted write.
//
// Ports
//   sys_clk, sys_rst          clock / asynchronous active-high reset
//   cmd_valid, cmd_ready      command handshake (accepted only in IDLE)
//   cmd_x0/x1, cmd_y0/y1      corner coordinates, either order
//   cmd_color                 fill colour
//   abort                     stop the current fill (SETUP / FILL only)
//   busy                      engine not idle
//   done                      one-cycle pulse at the end of every fill
//   src_write, src_rdy        pixel write request / core accepts this cycle
//   src_read                  always 0
//   src_x, src_y              pixel coordinate
//   src_writedata             {zero pad, colour}
//
// Build option
//   VGA_RECT_CLIP_EN  when defined, the rectangle is clipped to the visible
//                     H_DISPLAY x V_DISPLAY area in SETUP; a rectangle that
//                     lies completely outside produces no writes. When not
//                     defined the caller keeps coordinates in range.
// ----------------------------------------------------------------------------
module vga_rect_fill
    import vga_rect_pkg::*;
#(
    parameter int H_SIZE    = RECT_H_SIZE,
    parameter int V_SIZE    = RECT_V_SIZE,
    parameter int H_DISPLAY = 640,
    parameter int V_DISPLAY = 480,
    parameter int SRAM_DW   = 16,
    parameter int RGB_SIZE  = RECT_RGB_SIZE
) (
    input  logic                sys_clk,
    input  logic                sys_rst,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [H_SIZE-1:0]   cmd_x0,
    input  logic [H_SIZE-1:0]   cmd_x1,
    input  logic [V_SIZE-1:0]   cmd_y0,
    input  logic [V_SIZE-1:0]   cmd_y1,
    input  logic [RGB_SIZE-1:0] cmd_color,
    input  logic                abort,

    output logic                busy,
    output logic                done,

    output logic                src_write,
    output logic                src_read,
    output logic [H_SIZE-1:0]   src_x,
    output logic [V_SIZE-1:0]   src_y,
    output logic [SRAM_DW-1:0]  src_writedata,
    input  logic                src_rdy
);

    rect_state_t          state_q;
    logic [H_SIZE-1:0]    xl_q;
    logic [H_SIZE-1:0]    xh_q;
    logic [V_SIZE-1:0]    yl_q;
    logic [V_SIZE-1:0]    yh_q;
    logic [H_SIZE-1:0]    curX_q;
    logic [V_SIZE-1:0]    curY_q;
    logic                 srcWrite_q;
    logic                 done_q;
    logic [SRAM_DW-1:0]   srcWritedata_q;

    rect_cmd_t            cmdIn;
    logic [H_SIZE-1:0]    cmdXl;
    logic [H_SIZE-1:0]    cmdXh;
    logic [V_SIZE-1:0]    cmdYl;
    logic [V_SIZE-1:0]    cmdYh;
    logic                 accept;
    logic                 lastX;
    logic                 lastY;

`ifdef VGA_RECT_CLIP_EN
    localparam logic [H_SIZE-1:0] H_LAST = H_SIZE'(H_DISPLAY - 1);
    localparam logic [V_SIZE-1:0] V_LAST = V_SIZE'(V_DISPLAY - 1);
    logic [H_SIZE-1:0]    xhClip;
    logic [V_SIZE-1:0]    yhClip;
    logic                 rectEmpty;
`else
    // Display size only matters for clipping; keep it visibly consumed.
    logic [31:0]          unusedDisplay;
    assign unusedDisplay = 32'(H_DISPLAY + V_DISPLAY);
`endif

    // Command port gathered into the shared command struct, then normalised
    // so that xl <= xh and yl <= yh regardless of corner order.
    assign cmdIn.x0    = cmd_x0;
    assign cmdIn.x1    = cmd_x1;
    assign cmdIn.y0    = cmd_y0;
    assign cmdIn.y1    = cmd_y1;
    assign cmdIn.color = cmd_color;

    assign cmdXl = (cmdIn.x0 < cmdIn.x1) ? cmdIn.x0 : cmdIn.x1;
    assign cmdXh = (cmdIn.x0 < cmdIn.x1) ? cmdIn.x1 : cmdIn.x0;
    assign cmdYl = (cmdIn.y0 < cmdIn.y1) ? cmdIn.y0 : cmdIn.y1;
    assign cmdYh = (cmdIn.y0 < cmdIn.y1) ? cmdIn.y1 : cmdIn.y0;

`ifdef VGA_RECT_CLIP_EN
    // Clipping is evaluated while in SETUP on the already-normalised corners.
    assign xhClip    = (xh_q > H_LAST) ? H_LAST : xh_q;
    assign yhClip    = (yh_q > V_LAST) ? V_LAST : yh_q;
    assign rectEmpty = (xl_q > H_LAST) || (yl_q > V_LAST);
`endif

    assign accept = srcWrite_q && src_rdy;
    assign lastX  = (curX_q == xh_q);
    assign lastY  = (curY_q == yh_q);

    // Single-process FSM. All port-facing outputs are registers so the core
    // sees clean, glitch-free write requests; src_x/src_y are the walk
    // counters themselves and simply hold whenever a write is not accepted.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q        <= IDLE;
            xl_q           <= '0;
            xh_q           <= '0;
            yl_q           <= '0;
            yh_q           <= '0;
            curX_q         <= '0;
            curY_q         <= '0;
            srcWrite_q     <= 1'b0;
            done_q         <= 1'b0;
            srcWritedata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q     <= 1'b0;
                    srcWrite_q <= 1'b0;
                    if (cmd_valid) begin
                        xl_q           <= cmdXl;
                        xh_q           <= cmdXh;
                        yl_q           <= cmdYl;
                        yh_q           <= cmdYh;
                        srcWritedata_q <= SRAM_DW'(cmdIn.color);
                        state_q        <= SETUP;
                    end
                end

                SETUP: begin
                    curX_q <= xl_q;
                    curY_q <= yl_q;
                    if (abort) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
`ifdef VGA_RECT_CLIP_EN
                        xh_q <= xhClip;
                        yh_q <= yhClip;
                        if (rectEmpty) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            srcWrite_q <= 1'b1;
                            state_q    <= FILL;
                        end
`else
                        srcWrite_q <= 1'b1;
                        state_q    <= FILL;
`endif
                    end
                end

                FILL: begin
                    // An accept in the abort cycle still counts; the core has
                    // already taken that pixel, so only the request stops.
                    if (abort || (accept && lastX && lastY)) begin
                        srcWrite_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end else if (accept) begin
                        if (lastX) begin
                            curX_q <= xl_q;
                            curY_q <= curY_q + 1'b1;
                        end else begin
                            curX_q <= curX_q + 1'b1;
                        end
                    end
                end

                DONE: begin
                    done_q     <= 1'b0;
                    srcWrite_q <= 1'b0;
                    state_q    <= IDLE;
                end

                default: begin
                    done_q     <= 1'b0;
                    srcWrite_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign src_write     = srcWrite_q;
    assign src_read      = 1'b0;
    assign src_x         = curX_q;
    assign src_y         = curY_q;
    assign src_writedata = srcWritedata_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// ----------------------------------------------------------------------------
// tb_vga_rect_fill
//
// Self-checking bench for vga_rect_fill. Each command pushes the pixels it
// should produce (computed from the rectangle definition) into a queue; a
// monitor pops one entry per accepted write and compares coordinates and
// data. Done pulses, latency and reset behaviour are checked separately.
// ----------------------------------------------------------------------------
module tb_vga_rect_fill;

    localparam int HD = 640;
    localparam int VD = 480;

    typedef struct {
        int x;
        int y;
        int d;
    } pix_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x0 = '0;
    logic [9:0]  cmd_x1 = '0;
    logic [9:0]  cmd_y0 = '0;
    logic [9:0]  cmd_y1 = '0;
    logic [11:0] cmd_color = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        src_write;
    logic        src_read;
    logic [9:0]  src_x;
    logic [9:0]  src_y;
    logic [15:0] src_writedata;
    logic        src_rdy = 1'b1;

    int   checks = 0;
    int   errors = 0;
    int   cycleCnt = 0;
    int   doneSeen = 0;
    int   doneCycle = 0;
    int   acceptCnt = 0;
    int   rdyMode = 0;
    int   patIdx = 0;
    logic patBits [0:7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    pix_t expQ [$];

    logic        holdValid = 1'b0;
    logic [9:0]  holdX;
    logic [9:0]  holdY;
    logic [15:0] holdD;

    vga_rect_fill dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_x0        (cmd_x0),
        .cmd_x1        (cmd_x1),
        .cmd_y0        (cmd_y0),
        .cmd_y1        (cmd_y1),
        .cmd_color     (cmd_color),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .src_write     (src_write),
        .src_read      (src_read),
        .src_x         (src_x),
        .src_y         (src_y),
        .src_writedata (src_writedata),
        .src_rdy       (src_rdy)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cycleCnt++;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: all pixels of the rectangle in raster order, optionally
    // truncated to the first 'limit' pixels (for aborted fills).
    function automatic int buildExpected(input int x0, input int x1, input int y0, input int y1,
                                         input int col, input int limit);
        int xl = (x0 < x1) ? x0 : x1;
        int xh = (x0 < x1) ? x1 : x0;
        int yl = (y0 < y1) ? y0 : y1;
        int yh = (y0 < y1) ? y1 : y0;
        int n  = 0;
        pix_t p;
`ifdef VGA_RECT_CLIP_EN
        if (xh > HD - 1) xh = HD - 1;
        if (yh > VD - 1) yh = VD - 1;
`endif
        for (int y = yl; y <= yh; y++) begin
            for (int x = xl; x <= xh; x++) begin
                if (limit < 0 || n < limit) begin
                    p.x = x;
                    p.y = y;
                    p.d = col;
                    expQ.push_back(p);
                end
                n++;
            end
        end
        return n;
    endfunction

    // Ready driver: 0 = always ready, 1 = random, 2 = fixed pattern per write
    always @(posedge sys_clk) begin
        #1;
        if (rdyMode == 0) begin
            src_rdy = 1'b1;
        end else if (rdyMode == 1) begin
            src_rdy = 1'($urandom_range(0, 1));
        end else begin
            if (src_write) begin
                src_rdy = patBits[patIdx % 8];
                patIdx++;
            end else begin
                src_rdy = 1'b1;
            end
        end
    end

    // Monitor: scoreboard pops on every accepted write
    always @(negedge sys_clk) begin
        pix_t p;
        if (!sys_rst) begin
            if (holdValid && src_write) begin
                checkOutput("holdX", src_x, holdX);
                checkOutput("holdY", src_y, holdY);
                checkOutput("holdData", src_writedata, holdD);
            end
            if (src_write && src_rdy) begin
                acceptCnt++;
                checkOutput("srcRead", src_read, 0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedWrite", 1, 0);
                end else begin
                    p = expQ.pop_front();
                    checkOutput("pixX", src_x, p.x);
                    checkOutput("pixY", src_y, p.y);
                    checkOutput("pixData", src_writedata, p.d);
                end
            end
            holdValid = src_write && !src_rdy;
            holdX = src_x;
            holdY = src_y;
            holdD = src_writedata;
            if (done) begin
                doneSeen++;
                doneCycle = cycleCnt;
                checkOutput("writesBeforeDone", expQ.size(), 0);
                checkOutput("srcWriteAtDone", src_write, 0);
            end
        end else begin
            holdValid = 1'b0;
        end
    end

    // Issue one command and wait for its done pulse. abortAfter > 0 asserts
    // abort in the cycle of that accepted write. expLatency < 0 skips the
    // latency check.
    task automatic applyStimulus(input int x0, input int x1, input int y0, input int y1,
                                 input int col, input int abortAfter, input int expLatency);
        int startCycle;
        int doneBefore;
        int acceptBase;
        int guard;
        int n;
        guard = 0;
        while (!cmd_ready && guard < 100) begin
            @(posedge sys_clk);
            guard++;
        end
        checkOutput("cmdReadyBeforeCmd", cmd_ready, 1);
        @(posedge sys_clk);
        #1;
        cmd_x0     = 10'(x0);
        cmd_x1     = 10'(x1);
        cmd_y0     = 10'(y0);
        cmd_y1     = 10'(y1);
        cmd_color  = 12'(col);
        cmd_valid  = 1'b1;
        startCycle = cycleCnt;
        doneBefore = doneSeen;
        acceptBase = acceptCnt;
        patIdx     = 0;
        n = buildExpected(x0, x1, y0, y1, col, abortAfter > 0 ? abortAfter : -1);
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
        guard = 0;
        while (doneSeen == doneBefore && guard < 5000) begin
            #1;
            if (abortAfter > 0)
                abort = src_write && src_rdy && (acceptCnt - acceptBase == abortAfter - 1);
            @(negedge sys_clk);
            #1;
            guard++;
            if (doneSeen == doneBefore) @(posedge sys_clk);
        end
        abort = 1'b0;
        checkOutput("doneTimeout", doneSeen - doneBefore, 1);
        if (expLatency >= 0)
            checkOutput("doneLatency", doneCycle - startCycle, expLatency);
        @(negedge sys_clk);
        #1;
        checkOutput("donePulseWidth", done, 0);
        checkOutput("busyAfterDone", busy, 0);
        checkOutput("writeCount", acceptCnt - acceptBase, (abortAfter > 0 && abortAfter < n) ? abortAfter : n);
    endtask

    initial begin
        int doneBefore;
        int w;
        int h;
        int x0;
        int y0;
        int mode;

        #2;
        checkOutput("rstSrcWrite", src_write, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstSrcX", src_x, 0);
        checkOutput("rstSrcY", src_y, 0);
        checkOutput("rstData", src_writedata, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        checkOutput("cmdReadyAfterRst", cmd_ready, 1);

        $display("[TB] basic 3x2 fill");
        rdyMode = 0;
        applyStimulus(2, 4, 1, 2, 12'hF00, 0, 8);
        $display("[TB] swapped corners");
        applyStimulus(4, 2, 2, 1, 12'hF00, 0, 8);
        $display("[TB] single pixel");
        applyStimulus(7, 7, 9, 9, 12'h0A5, 0, 3);
        $display("[TB] ready pattern 1-0-0-1 on 3x1");
        rdyMode = 2;
        applyStimulus(10, 12, 5, 5, 12'h123, 0, -1);
        rdyMode = 0;
        $display("[TB] abort on 2nd write of 10x10");
        applyStimulus(100, 109, 100, 109, 12'h5A5, 2, 4);
        checkOutput("cmdReadyAfterAbort", cmd_ready, 1);

`ifdef VGA_RECT_CLIP_EN
        $display("[TB] clipped corner");
        applyStimulus(638, 700, 478, 500, 12'hABC, 0, 6);
        $display("[TB] fully clipped");
        applyStimulus(650, 660, 0, 5, 12'h777, 0, 2);
`endif

        $display("[TB] randomized fills");
        for (int i = 0; i < 25; i++) begin
            w    = $urandom_range(1, 6);
            h    = $urandom_range(1, 4);
            x0   = $urandom_range(0, HD - w);
            y0   = $urandom_range(0, VD - h);
            mode = $urandom_range(0, 1);
            rdyMode = mode;
            if ($urandom_range(0, 1) == 1)
                applyStimulus(x0 + w - 1, x0, y0 + h - 1, y0, $urandom_range(0, 4095), 0,
                              mode == 0 ? w * h + 2 : -1);
            else
                applyStimulus(x0, x0 + w - 1, y0, y0 + h - 1, $urandom_range(0, 4095), 0,
                              mode == 0 ? w * h + 2 : -1);
        end
        rdyMode = 0;

        $display("[TB] reset during fill");
        @(posedge sys_clk);
        #1;
        cmd_x0 = 10'd20;  cmd_x1 = 10'd29;
        cmd_y0 = 10'd30;  cmd_y1 = 10'd39;
        cmd_color = 12'h0F0;
        cmd_valid = 1'b1;
        w = buildExpected(20, 29, 30, 39, 12'h0F0, -1);
        @(posedge sys_clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge sys_clk);
        @(negedge sys_clk);
        #2;
        checkOutput("writingBeforeRst", src_write, 1);
        doneBefore = doneSeen;
        sys_rst = 1'b1;
        #1;
        checkOutput("rstMidSrcWrite", src_write, 0);
        checkOutput("rstMidBusy", busy, 0);
        expQ.delete();
        repeat (2) @(negedge sys_clk);
        #2;
        sys_rst = 1'b0;
        repeat (4) @(negedge sys_clk);
        #1;
        checkOutput("noDoneAfterRst", doneSeen - doneBefore, 0);
        checkOutput("cmdReadyAfterMidRst", cmd_ready, 1);
        checkOutput("busyAfterMidRst", busy, 0);

        $display("[TB] fill after reset");
        applyStimulus(0, 1, 0, 1, 12'hFFF, 0, 6);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL globalTimeout: got running, expected finished");
        $fatal(1, "[TB] global timeout");
    end

endmodule
